xor_stream_cipher: RTL and testbench
====================================

Name: xor_stream_cipher

Overview:
- Parametrised next-generation XOR cipher engine. Replaces the fixed 32-bit-key / 512-bit-message / 1-bit serial deserialise→assemble→encrypt→serialise chain with a streaming datapath.
- Key is loaded LANE bits per cycle. Message lanes are encrypted on the fly with 1-cycle latency, and output is framed per MSG_BITS.
- Adds an LFSR keystream mode, frame start/end flags, drop reporting and mid-frame key-reload abort.

Parameters:
- KEY_BITS, 32, key register width; multiple of LANE, ≥32.
- MSG_BITS, 512, frame length in bits; multiple of LANE.
- LANE, 1, bits per cycle on data in/out (1, 2, 4 or 8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; when low, no state advances.
- i_data  in  LANE  serial key/message lane, MSB-first.
- i_load_key  in  1  current lane is key data.
- i_load_msg  in  1  current lane is message data.
- i_mode  in  1  0 = repeating key, 1 = LFSR keystream.
- o_data  out  LANE  ciphertext lane.
- o_valid  out  1  o_data valid this cycle.
- o_start  out  1  first lane of frame (with o_valid).
- o_end  out  1  last lane of frame (with o_valid).
- o_key_ready  out  1  full key loaded.
- o_drop  out  1  one-cycle pulse: message lane rejected.

Behaviour:
- Reset (async, rst_n low): all outputs 0; key_sr, key_cnt, msg_cnt, key_ptr and lfsr cleared; mode_q = 0.
- All state is held while ena = 0. o_valid, o_start, o_end and o_drop are 0 in that cycle, and o_data holds.
- FSM states:
  - NOKEY: after reset.
  - KEYLOAD.
  - READY: key valid, between frames.
  - STREAM: mid-frame.
- Key load (i_load_key & ena):
  - key_sr shifts left by LANE, with i_data entering the LSBs.
  - key_cnt increments.
  - At key_cnt == KEY_BITS/LANE: o_key_ready = 1 from the next cycle; go to READY.
- Key reload: i_load_key while in READY or STREAM clears o_key_ready, key_cnt and msg_cnt, and enters KEYLOAD.
  - If in STREAM, the frame is aborted with no o_end.
  - The first reload lane is shifted in.
- Message lane acceptance requires i_load_msg & ena & o_key_ready & !i_load_key.
  - i_load_msg & ena with o_key_ready = 0, or together with i_load_key, gives o_drop = 1 next cycle and no output. Key data wins.
- Frame start (accepted lane with msg_cnt = 0):
  - mode_q ← i_mode.
  - key_ptr ← 0.
  - lfsr ← key_sr[31:0], or 32'h00000001 if that value is zero.
  - The keystream for this lane uses the freshly initialised values.
- Keystream mode 0: lane = key_sr bits [KEY_BITS-1-key_ptr·LANE -: LANE]. key_ptr increments per lane and wraps from KEY_BITS/LANE-1 to 0.
- Keystream mode 1 (32-bit Fibonacci LFSR):
  - Output bit = lfsr[31]; next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
  - LANE steps per lane; the first generated bit maps to the lane MSB.
- Output (registered, 1-cycle latency after acceptance):
  - o_data = i_data ^ keystream lane; o_valid = 1.
  - o_start = (msg_cnt was 0).
  - o_end = (msg_cnt was MSG_BITS/LANE-1), then msg_cnt wraps to 0 and the FSM returns to READY.
  - Both flags are 1 simultaneously when MSG_BITS == LANE.
- Idle gaps (i_load_msg low) mid-frame are legal. Counters and LFSR hold; o_valid = 0.
- i_mode changes mid-frame are ignored until the next frame start.

Test Plan:
- KEY_BITS=32, MSG_BITS=64, LANE=1, mode 0, key 0xA5A50F0F, message 0x0123456789ABCDEF → 64 o_valid bits forming 0xA4864A682C0EC2E0. o_start on the first bit and o_end on the 64th; latency 1 cycle per bit.
- Same vectors with LANE=8 → 8 output bytes A4 86 4A 68 2C 0E C2 E0, o_start with A4 and o_end with E0. Second back-to-back frame restarts key_ptr and gives identical output.
- LANE=1, mode 1, key 0x00000000, message all zeros → seed forced to 1. Output bits 1–31 are 0, bit 32 is 1.
- i_load_msg before any key, then i_load_key and i_load_msg together → o_drop pulses each time, o_valid stays 0, and the key lane is shifted in.
- Key reload after 20 message bits, then a new key 0xFFFFFFFF and 64 message bits of 0 → no o_end for the aborted frame. New frame gives o_start and 64 bits of 1 ending with o_end.
- rst_n low mid-frame while ena toggles → all outputs 0 immediately and o_key_ready = 0. No output advances during any ena = 0 cycle.

Source files
------------

// File: rtl/xor_stream_cipher.sv
// Streaming XOR cipher: LANE-wide key load, on-the-fly encryption with a repeating-key
// or 32-bit LFSR keystream, framed output with start/end flags and drop reporting.
//
// state   | meaning
// NOKEY   | no key loaded since reset
// KEYLOAD | key lanes being shifted in, message lanes dropped
// READY   | key valid, between frames
// STREAM  | key valid, inside a frame
module xor_stream_cipher #(
  parameter int KEY_BITS = 32,
  parameter int MSG_BITS = 512,
  parameter int LANE     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [LANE-1:0] i_data,
  input  logic            i_load_key,
  input  logic            i_load_msg,
  input  logic            i_mode,
  output logic [LANE-1:0] o_data,
  output logic            o_valid,
  output logic            o_start,
  output logic            o_end,
  output logic            o_key_ready,
  output logic            o_drop
);
  localparam int KEY_LANES = KEY_BITS / LANE;
  localparam int MSG_LANES = MSG_BITS / LANE;
  localparam int PW        = $clog2(KEY_LANES);
  localparam int MW        = (MSG_LANES > 1) ? $clog2(MSG_LANES) : 1;

  typedef enum logic [1:0] {NOKEY, KEYLOAD, READY, STREAM} state_t;

  state_t                state_q, state_d;
  logic [KEY_BITS-1:0]   key_sr, key_rot;
  logic [PW-1:0]         key_cnt, key_cnt_base, key_ptr, ptr_eff;
  logic [MW-1:0]         msg_cnt;
  logic [31:0]           lfsr, lfsr_eff, lfsr_nx, seed;
  logic                  mode_q, mode_eff;
  logic [LANE-1:0]       ks;
  logic                  key_in, accept, frame_first, last_lane, key_done;

  assign key_in       = ena & i_load_key;
  assign accept       = ena & i_load_msg & o_key_ready & ~i_load_key;
  assign frame_first  = (msg_cnt == '0);
  assign last_lane    = (msg_cnt == MW'(MSG_LANES - 1));
  assign key_cnt_base = o_key_ready ? '0 : key_cnt;
  assign key_done     = key_in & ~o_key_ready & (key_cnt == PW'(KEY_LANES - 1));

  // First lane of a frame must use the freshly initialised keystream state.
  assign seed     = key_sr[31:0];
  assign ptr_eff  = frame_first ? '0 : key_ptr;
  assign mode_eff = frame_first ? i_mode : mode_q;
  assign lfsr_eff = frame_first ? ((seed == '0) ? 32'd1 : seed) : lfsr;

  always_comb begin
    key_rot = key_sr << (int'(ptr_eff) * LANE);
    ks      = '0;
    lfsr_nx = lfsr_eff;
    for (int i = 0; i < LANE; i++) begin
      if (mode_eff) ks[LANE-1-i] = lfsr_nx[31];
      lfsr_nx = {lfsr_nx[30:0], lfsr_nx[31] ^ lfsr_nx[21] ^ lfsr_nx[1] ^ lfsr_nx[0]};
    end
    if (!mode_eff) ks = key_rot[KEY_BITS-1 -: LANE];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NOKEY:   if (key_in) state_d = KEYLOAD;
      KEYLOAD: if (key_done) state_d = READY;
      READY: begin
        if (key_in) state_d = KEYLOAD;
        else if (accept && !last_lane) state_d = STREAM;
      end
      STREAM: begin
        if (key_in) state_d = KEYLOAD;
        else if (accept && last_lane) state_d = READY;
      end
      default: state_d = NOKEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= NOKEY;
    else if (ena) state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sr      <= '0;
      key_cnt     <= '0;
      key_ptr     <= '0;
      msg_cnt     <= '0;
      lfsr        <= '0;
      mode_q      <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_start     <= 1'b0;
      o_end       <= 1'b0;
      o_key_ready <= 1'b0;
      o_drop      <= 1'b0;
    end else if (!ena) begin
      o_valid <= 1'b0;
      o_start <= 1'b0;
      o_end   <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      o_valid <= accept;
      o_start <= accept & frame_first;
      o_end   <= accept & last_lane;
      o_drop  <= i_load_msg & (i_load_key | ~o_key_ready);
      if (i_load_key) begin
        // Key data always wins; a reload mid-frame abandons the frame silently.
        key_sr      <= {key_sr[KEY_BITS-LANE-1:0], i_data};
        key_cnt     <= key_done ? '0 : key_cnt_base + PW'(1);
        o_key_ready <= key_done;
        msg_cnt     <= '0;
      end else if (accept) begin
        o_data  <= i_data ^ ks;
        msg_cnt <= last_lane ? '0 : msg_cnt + MW'(1);
        key_ptr <= (ptr_eff == PW'(KEY_LANES - 1)) ? '0 : ptr_eff + PW'(1);
        lfsr    <= lfsr_nx;
        mode_q  <= mode_eff;
      end
    end
  end
endmodule

// File: tb/tb_xor_stream_cipher.sv
// Bench for xor_stream_cipher: LANE=1 and LANE=8 instances checked every cycle against
// a bit-level behavioural model, plus literal vectors from hand-computed examples.
module tb_xor_stream_cipher;
  logic clk = 1'b0;
  logic rst_n;
  logic ena1, lk1, lm1, md1;
  logic [0:0] d1;
  logic ena8, lk8, lm8, md8;
  logic [7:0] d8;
  logic [0:0] o_data1;
  logic [7:0] o_data8;
  logic o_valid1, o_start1, o_end1, o_kr1, o_drop1;
  logic o_valid8, o_start8, o_end8, o_kr8, o_drop8;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  xor_stream_cipher #(.KEY_BITS(32), .MSG_BITS(64), .LANE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .i_data(d1), .i_load_key(lk1), .i_load_msg(lm1),
    .i_mode(md1), .o_data(o_data1), .o_valid(o_valid1), .o_start(o_start1), .o_end(o_end1),
    .o_key_ready(o_kr1), .o_drop(o_drop1));

  xor_stream_cipher #(.KEY_BITS(32), .MSG_BITS(64), .LANE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena8), .i_data(d8), .i_load_key(lk8), .i_load_msg(lm8),
    .i_mode(md8), .o_data(o_data8), .o_valid(o_valid8), .o_start(o_start8), .o_end(o_end8),
    .o_key_ready(o_kr8), .o_drop(o_drop8));

  // Behavioural model state, index 0 = LANE 1, index 1 = LANE 8
  logic [31:0] m_key[2], m_lfsr[2];
  int          m_kbits[2], m_pos[2], m_kpos[2];
  bit          m_ready[2], m_mode[2];
  bit          e_valid[2], e_start[2], e_end[2], e_drop[2];
  logic [7:0]  e_data[2];

  // Observed-output capture
  logic [63:0]  cap1;
  logic [127:0] cap8;
  int n_s[2], n_e[2], n_d[2], n_v[2];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void mreset();
    for (int k = 0; k < 2; k++) begin
      m_key[k] = '0; m_lfsr[k] = '0; m_kbits[k] = 0; m_pos[k] = 0; m_kpos[k] = 0;
      m_ready[k] = 0; m_mode[k] = 0;
      e_valid[k] = 0; e_start[k] = 0; e_end[k] = 0; e_drop[k] = 0; e_data[k] = '0;
    end
  endfunction

  function automatic void mstep(input int k, input int L, input bit e, input bit lk,
                                input bit lm, input bit md, input logic [7:0] d);
    logic [7:0] mask, ks;
    bit b;
    mask = (L == 8) ? 8'hFF : 8'h01;
    e_valid[k] = 0; e_start[k] = 0; e_end[k] = 0; e_drop[k] = 0;
    if (!e) return;
    e_drop[k] = lm && (!m_ready[k] || lk);
    if (lk) begin
      m_key[k] = (m_key[k] << L) | {24'b0, d & mask};
      if (m_ready[k]) begin
        m_ready[k] = 0; m_kbits[k] = 0; m_pos[k] = 0;
      end
      m_kbits[k] += L;
      if (m_kbits[k] == 32) begin
        m_ready[k] = 1; m_kbits[k] = 0;
      end
    end else if (lm && m_ready[k]) begin
      if (m_pos[k] == 0) begin
        m_mode[k] = md; m_kpos[k] = 0;
        m_lfsr[k] = (m_key[k] == 0) ? 32'd1 : m_key[k];
      end
      ks = '0;
      for (int j = 0; j < L; j++) begin
        if (m_mode[k]) begin
          b = m_lfsr[k][31];
          m_lfsr[k] = {m_lfsr[k][30:0],
                       m_lfsr[k][31] ^ m_lfsr[k][21] ^ m_lfsr[k][1] ^ m_lfsr[k][0]};
        end else begin
          b = m_key[k][31 - m_kpos[k]];
          m_kpos[k] = (m_kpos[k] + 1) % 32;
        end
        ks = {ks[6:0], b};
      end
      e_data[k]  = (d ^ ks) & mask;
      e_valid[k] = 1;
      e_start[k] = (m_pos[k] == 0);
      e_end[k]   = (m_pos[k] == 64 / L - 1);
      m_pos[k]   = (m_pos[k] + 1) % (64 / L);
    end
  endfunction

  // Single compare process: DUT outputs vs model, every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid1", o_valid1, e_valid[0]);
      check("start1", o_start1, e_start[0]);
      check("end1",   o_end1,   e_end[0]);
      check("drop1",  o_drop1,  e_drop[0]);
      check("kr1",    o_kr1,    m_ready[0]);
      check("data1",  {7'b0, o_data1}, e_data[0]);
      check("valid8", o_valid8, e_valid[1]);
      check("start8", o_start8, e_start[1]);
      check("end8",   o_end8,   e_end[1]);
      check("drop8",  o_drop8,  e_drop[1]);
      check("kr8",    o_kr8,    m_ready[1]);
      check("data8",  o_data8,  e_data[1]);
      if (o_valid1) begin cap1 = {cap1[62:0], o_data1}; n_v[0]++; end
      if (o_valid8) begin cap8 = {cap8[119:0], o_data8}; n_v[1]++; end
      if (o_valid1 && o_start1) n_s[0]++;
      if (o_valid1 && o_end1)   n_e[0]++;
      if (o_valid8 && o_start8) n_s[1]++;
      if (o_valid8 && o_end8)   n_e[1]++;
      if (o_drop1) n_d[0]++;
      if (o_drop8) n_d[1]++;
    end
  end

  task automatic tick();
    if (!rst_n) mreset();
    else begin
      mstep(0, 1, ena1, lk1, lm1, md1, {7'b0, d1});
      mstep(1, 8, ena8, lk8, lm8, md8, d8);
    end
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    lk1 = 0; lm1 = 0; lk8 = 0; lm8 = 0; ena1 = 1; ena8 = 1;
  endtask

  task automatic clr();
    cap1 = '0; cap8 = '0;
    for (int k = 0; k < 2; k++) begin n_s[k] = 0; n_e[k] = 0; n_d[k] = 0; n_v[k] = 0; end
  endtask

  task automatic key1_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      lk1 = 1; d1 = w[i]; tick();
    end
    lk1 = 0;
  endtask

  task automatic msg1(input logic [63:0] v, input bit md, input int n);
    for (int i = 63; i > 63 - n; i--) begin
      lm1 = 1; md1 = md; d1 = v[i]; tick();
    end
    lm1 = 0; tick();
  endtask

  task automatic key8(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      lk8 = 1; d8 = w[31 - 8*i -: 8]; tick();
    end
    lk8 = 0;
  endtask

  task automatic msg8(input logic [63:0] v, input bit md, input int frames);
    for (int f = 0; f < frames; f++)
      for (int i = 0; i < 8; i++) begin
        lm8 = 1; md8 = md; d8 = v[63 - 8*i -: 8]; tick();
      end
    lm8 = 0; tick();
  endtask

  task automatic rnd_ctl(inout int kb, input int kmax, output logic e, output logic lk,
                         output logic lm, output logic md);
    e = ($urandom % 10) != 0;
    md = $urandom % 2;
    if (kb > 0) begin
      lk = 1; lm = ($urandom % 8) == 0;
      if (e) kb--;
    end else begin
      lk = ($urandom % 100) == 0;
      lm = ($urandom % 4) != 0;
      if (($urandom % 120) == 0) kb = $urandom_range(1, kmax);
    end
  endtask

  initial begin
    int kb1, kb8;
    rst_n = 0; d1 = 0; d8 = 0; md1 = 0; md8 = 0;
    idle();
    mreset(); clr();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1; chk_en = 1;

    // Drops before any key, then key+msg together: key bit must still shift in
    lm1 = 1; tick();
    lm1 = 0; tick();
    lk1 = 1; lm1 = 1; d1 = 1'b1; tick();
    lm1 = 0;
    key1_bits(32'hA5A50F0F, 31);
    tick();
    check("drop_count", n_d[0], 2);
    check("no_valid_on_drop", n_v[0], 0);
    check("kr_after_load", o_kr1, 1);

    // LANE=1 mode 0 frame
    clr();
    msg1(64'h0123456789ABCDEF, 1'b0, 64);
    check("lane1_cipher", cap1, 64'hA4864A682C0EC2E0);
    check("lane1_starts", n_s[0], 1);
    check("lane1_ends", n_e[0], 1);

    // LANE=8, two back-to-back frames
    key8(32'hA5A50F0F);
    clr();
    msg8(64'h0123456789ABCDEF, 1'b0, 2);
    check("lane8_cipher", cap8, {64'hA4864A682C0EC2E0, 64'hA4864A682C0EC2E0});
    check("lane8_starts", n_s[1], 2);
    check("lane8_ends", n_e[1], 2);

    // LFSR with zero key: seed forced to 1
    key1_bits(32'h0, 32);
    clr();
    msg1(64'h0, 1'b1, 64);
    check("lfsr_first31", cap1[63:33], 31'h0);
    check("lfsr_bit32", cap1[32], 1'b1);

    // Reload mid-frame aborts it
    key1_bits(32'h12345678, 32);
    clr();
    msg1(64'hDEADBEEF_00000000, 1'b0, 20);
    key1_bits(32'hFFFFFFFF, 32);
    msg1(64'h0, 1'b0, 64);
    check("reload_cipher", cap1, 64'hFFFFFFFFFFFFFFFF);
    check("reload_starts", n_s[0], 2);
    check("reload_ends", n_e[0], 1);
    check("reload_valids", n_v[0], 84);

    // Async reset mid-frame while ena toggles
    for (int i = 0; i < 6; i++) begin
      ena8 = i[0]; lm8 = 1; md8 = 0; d8 = 8'($urandom); tick();
    end
    rst_n = 0; mreset();
    #1;
    check("rst_valid8", o_valid8, 0);
    check("rst_data8", o_data8, 0);
    check("rst_kr8", o_kr8, 0);
    check("rst_kr1", o_kr1, 0);
    for (int i = 0; i < 3; i++) begin
      ena8 = i[0]; ena1 = ~i[0]; tick();
    end
    rst_n = 1; idle(); tick();

    // Randomized traffic on both instances
    kb1 = 40; kb8 = 5;
    for (int c = 0; c < 4000; c++) begin
      rnd_ctl(kb1, 40, ena1, lk1, lm1, md1);
      rnd_ctl(kb8, 6, ena8, lk8, lm8, md8);
      d1 = 1'($urandom); d8 = 8'($urandom);
      tick();
    end
    idle(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1);
  end
endmodule
